spi_word_receiver: RTL and testbench
====================================

// Module: spi_word_receiver
// PURPOSE
//  SPI slave (mode 0, MSB first) that assembles host bytes into 16-bit words and
//  writes them into the WS2812 output stage's frame buffer. Sits directly upstream
//  of the LED shift-out stage and drives its spi_data/spi_address/spi_write_strobe.
//  One CS-low transaction carries one frame; the address auto-increments per word.
// PARAMETERS
//  WORD_WIDTH   16    bits per buffer word; SPI bits collected before each write
//  ADDR_WIDTH   11    width of spi_address
//  NUM_WORDS    1305  frame-buffer depth (30*29*3 bytes / 2)
//  SYNC_STAGES  2     flip-flops in each SCK/MOSI/CS_N synchronizer (>=2)
// PORTS
//  clock             in   1           system clock; must be >= 4x SCK frequency
//  reset_n           in   1           asynchronous, active-low reset
//  spi_sck           in   1           SPI clock, asynchronous to clock
//  spi_mosi          in   1           SPI data in, sampled on SCK rising edge
//  spi_cs_n          in   1           SPI chip select, active low
//  spi_data          out  WORD_WIDTH  assembled word; valid while strobe is high
//  spi_address       out  ADDR_WIDTH  word index for spi_data
//  spi_write_strobe  out  1           one-cycle write pulse to the frame buffer
//  frame_done        out  1           one-cycle pulse on CS_N deassertion
//  overflow          out  1           sticky: word(s) beyond NUM_WORDS-1 dropped
// BEHAVIOUR
//  - Reset (async on reset_n low): all outputs 0; shift reg, bit count, address 0;
//    synchronizers preset to idle (SCK=0, CS_N=1); state IDLE.
//  - Inputs pass SYNC_STAGES FFs, then one history FF; sck_rise = s & ~s_d,
//    cs_fall/cs_rise likewise. MOSI is delayed by the same depth as SCK.
//  - States: IDLE -> RECV on cs_fall (bit count 0, address 0, overflow cleared).
//    RECV: each sck_rise shifts MOSI into LSB (MSB first); on 16th bit, the next
//    cycle drives spi_data=word, spi_address=addr, spi_write_strobe=1 for exactly 1
//    cycle, then addr increments. Write occurs 1 cycle after 16th sck_rise detected.
//    After the word at NUM_WORDS-1 is written -> FULL.
//    FULL: further complete words produce no strobe; overflow set on first dropped word.
//    Any state -> IDLE on cs_rise; frame_done pulses 1 cycle in that same transition.
//  - Partial word (<16 bits) at cs_rise is discarded; no strobe.
//  - cs_rise and 16th sck_rise in the same cycle: word is written, then IDLE.
//  - cs_fall while in RECV/FULL (glitch with no seen rise): restart as fresh frame.
//  - Address never wraps; spi_address holds last written value between strobes.
//  - sck_rise while CS_N high is ignored.
//  - reset_n low mid-transaction: abort immediately; no strobe, no frame_done.
// CONFIGURATION
//  SPI_ADDR_HEADER_EN defined: first 16-bit word of each transaction is a start
//   address, not data; no strobe for it. Value >= NUM_WORDS -> FULL with overflow=1.
//   Following words write from that address upward.
//  SPI_ADDR_HEADER_EN undefined: every transaction starts writing at address 0.
// STRUCTURE
//  supersweet_pkg: WORD_WIDTH, ADDR_WIDTH, NUM_WORDS constants, rx state enum
//   (IDLE, HEADER, RECV, FULL); shared with the WS2812 output stage.
//  Sub-module spi_input_sync: parameterised synchronizer + edge detector
//   (outputs level, rise, fall); one instance each for SCK and CS_N; MOSI
//   uses delay-only path.
// TESTING
//  1 CS low, send 0xA55A,0x1234, CS high -> strobes (addr0,A55A),(addr1,1234);
//    one frame_done; overflow 0.
//  2 Send 24 bits (0xBEEF + 0xCC) then CS high -> one strobe (0,BEEF); 8 bits
//    dropped; next frame starts at addr 0.
//  3 Send 1306 words -> 1305 strobes, last addr 1304; overflow=1 after word 1306.
//  4 reset_n low after 9 bits of word 0 -> outputs 0 at once; no strobe after
//    release until new CS fall.
//  5 SCK toggling with CS_N high -> no strobes, no shift-in.
//  6 HEADER_EN: send 0x0010,0x00FF -> single strobe (addr 16,00FF);
//    header 0x0519 -> no strobe, overflow=1.

Source files
------------

// File: rtl/supersweet_pkg.sv
// supersweet_pkg
//   Constants and types shared between the SPI word receiver and the WS2812
//   output stage. The frame buffer is 30*29 pixels * 3 bytes, packed two bytes
//   per 16-bit word, so it is 1305 words deep and needs an 11-bit address.
//   rx_state_t is the receiver's frame state:
//     IDLE   - chip select high, waiting for a frame
//     HEADER - collecting the start-address word (header build only)
//     RECV   - writing words into the frame buffer
//     FULL   - buffer end reached; further complete words are dropped
package supersweet_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 11;
    localparam int NUM_WORDS  = 1305;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        RECV   = 2'd2,
        FULL   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync
//   Brings one asynchronous SPI pin into the clock domain and detects its edges.
//   SYNC_STAGES flip-flops of metastability protection are followed by one
//   history flip-flop, so rise/fall are single-cycle pulses aligned with the
//   new synchronized level.
// Parameters
//   SYNC_STAGES  synchronizer depth, must be >= 2
//   IDLE_LEVEL   value all flops take in reset (the pin's idle level)
// Ports
//   clock     in   system clock
//   reset_n   in   asynchronous active-low reset
//   async_in  in   raw pin
//   level     out  synchronized level
//   rise      out  one-cycle pulse on a 0->1 transition of level
//   fall      out  one-cycle pulse on a 1->0 transition of level
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Presetting to the idle level keeps reset release from looking like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            hist_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_word_receiver.sv
// spi_word_receiver
//   SPI slave (mode 0, MSB first). Each chip-select-low transaction is one frame;
//   every 16 received bits become one write into the WS2812 frame buffer at an
//   auto-incrementing word address. Word geometry comes from supersweet_pkg so
//   it always matches the output stage.
// Configuration
//   SPI_ADDR_HEADER_EN  defined: the first word of each frame is the start
//                       address (no write); an address >= NUM_WORDS makes the
//                       whole frame overflow. Undefined: frames start at 0.
// Parameters
//   SYNC_STAGES  synchronizer depth for SCK/MOSI/CS_N (>= 2)
// Ports
//   clock             in   system clock, >= 4x SCK
//   reset_n           in   asynchronous active-low reset
//   spi_sck           in   SPI clock (asynchronous)
//   spi_mosi          in   SPI data, sampled on SCK rise
//   spi_cs_n          in   SPI chip select, active low
//   spi_data          out  word being written (valid with strobe)
//   spi_address       out  word address, holds last written value
//   spi_write_strobe  out  one-cycle frame-buffer write
//   frame_done        out  one-cycle pulse when CS_N deasserts
//   overflow          out  sticky per frame: word(s) past the buffer end dropped
module spi_word_receiver
    import supersweet_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic [WORD_WIDTH-1:0] spi_data,
    output logic [ADDR_WIDTH-1:0] spi_address,
    output logic                  spi_write_strobe,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WORD_WIDTH);

    // ---------------- input synchronization ----------------
    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (spi_sck),
        .level    (sck_level),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // cs_fall = chip select asserted, cs_rise = chip select released
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (spi_cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // MOSI gets the same depth as the SCK level, so the bit seen in the
    // sck_rise cycle is the one that was stable around the real SCK edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) mosi_q <= '0;
        else          mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    logic unused_sync;
    assign unused_sync = ^{sck_level, sck_fall, cs_level};

    // ---------------- frame state machine ----------------
    rx_state_t             state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic                  strobe_d, done_d, ovf_d;
    logic [WORD_WIDTH-1:0] word;
    logic                  word_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            shift_q          <= '0;
            cnt_q            <= '0;
            addr_q           <= '0;
            spi_data         <= '0;
            spi_address      <= '0;
            spi_write_strobe <= 1'b0;
            frame_done       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            state_q          <= state_d;
            shift_q          <= shift_d;
            cnt_q            <= cnt_d;
            addr_q           <= addr_d;
            spi_data         <= data_d;
            spi_address      <= address_d;
            spi_write_strobe <= strobe_d;
            frame_done       <= done_d;
            overflow         <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = spi_data;
        address_d = spi_address;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        ovf_d     = overflow;
        word      = {shift_q[WORD_WIDTH-2:0], mosi_s};
        word_done = 1'b0;

        if (cs_fall) begin
            // Also taken from RECV/FULL: a CS glitch whose rise we never saw
            // simply restarts the frame.
`ifdef SPI_ADDR_HEADER_EN
            state_d = HEADER;
`else
            state_d = RECV;
`endif
            shift_d = '0;
            cnt_d   = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (state_q != IDLE && sck_rise) begin
                word_done = (cnt_q == CNT_W'(WORD_WIDTH - 1));
                shift_d   = word;
                cnt_d     = word_done ? '0 : cnt_q + 1'b1;
            end

            if (word_done) begin
                case (state_q)
                    HEADER: begin
                        if (word < WORD_WIDTH'(NUM_WORDS)) begin
                            addr_d  = word[ADDR_WIDTH-1:0];
                            state_d = RECV;
                        end else begin
                            state_d = FULL;
                            ovf_d   = 1'b1;
                        end
                    end
                    RECV: begin
                        data_d    = word;
                        address_d = addr_q;
                        strobe_d  = 1'b1;
                        // Stop at the last word instead of wrapping onto pixel 0.
                        if (addr_q == ADDR_WIDTH'(NUM_WORDS - 1)) state_d = FULL;
                        else                                      addr_d  = addr_q + 1'b1;
                    end
                    FULL:    ovf_d = 1'b1;
                    default: ;
                endcase
            end

            // A word completing in the same cycle is still written above; any
            // partial word is abandoned with the frame.
            if (cs_rise) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_word_receiver.sv
module tb_spi_word_receiver;
    import supersweet_pkg::*;

    logic clock = 1'b0;
    logic reset_n, spi_sck, spi_mosi, spi_cs_n;
    logic [WORD_WIDTH-1:0] spi_data;
    logic [ADDR_WIDTH-1:0] spi_address;
    logic spi_write_strobe, frame_done, overflow;

    always #5 clock = ~clock;

    spi_word_receiver #(.SYNC_STAGES(2)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .spi_sck          (spi_sck),
        .spi_mosi         (spi_mosi),
        .spi_cs_n         (spi_cs_n),
        .spi_data         (spi_data),
        .spi_address      (spi_address),
        .spi_write_strobe (spi_write_strobe),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

`ifdef SPI_ADDR_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t         exp_q[$];     // writes the model says must appear, in order
    logic [31:0] seen_q[$];    // {addr, data} of strobes seen this frame
    int n_checks = 0, n_pass = 0;
    int exp_done = 0, seen_done = 0;

    // frame model
    int m_addr, m_nbits, m_word;
    bit m_ovf, m_hdr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // A completed 16-bit word in the current frame.
    task automatic model_word(input int w);
        if (m_hdr) begin
            m_hdr = 1'b0;
            if (w >= NUM_WORDS) begin
                m_addr = NUM_WORDS;
                m_ovf  = 1'b1;
            end else begin
                m_addr = w;
            end
        end else if (m_addr < NUM_WORDS) begin
            exp_q.push_back('{addr: m_addr, data: w});
            m_addr++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        #20 spi_sck = 1'b1;
        if (!spi_cs_n) begin
            m_word  = ((m_word << 1) | int'(b)) & 32'hFFFF;
            m_nbits = m_nbits + 1;
            if (m_nbits == WORD_WIDTH) begin
                m_nbits = 0;
                model_word(m_word);
            end
        end
        #20 spi_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [15:0] v);
        send_bits(v, 16);
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        m_addr = 0; m_nbits = 0; m_word = 0; m_ovf = 1'b0; m_hdr = HDR;
        seen_q.delete();
        #60;
        check("ovf_cleared_on_cs_fall", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cs_end();
        #20 spi_cs_n = 1'b1;
        exp_done++;
        #100;
        check("missing_strobes", 32'(exp_q.size()), 32'd0);
        check("frame_done_count", 32'(seen_done), 32'(exp_done));
        check("overflow_at_end", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},     32'(spi_data), 32'd0);
        check({tag, "_address"},  32'(spi_address), 32'd0);
        check({tag, "_strobe"},   32'(spi_write_strobe), 32'd0);
        check({tag, "_done"},     32'(frame_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Every cycle: each strobe must match the next expected write, in order.
    always @(negedge clock) begin : cmp
        wr_t e;
        if (reset_n === 1'b1) begin
            if (frame_done) seen_done++;
            if (spi_write_strobe) begin
                seen_q.push_back({5'd0, spi_address, spi_data});
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(spi_write_strobe), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_addr", 32'(spi_address), e.addr);
                    check("strobe_data", 32'(spi_data), e.data);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        m_addr = 0; m_nbits = 0; m_word = 0; m_ovf = 1'b0; m_hdr = HDR;
        #1;
        check_reset_outputs("reset");
        #49 reset_n = 1'b1;
        #50;

        // 1: two words in one frame
        cs_start();
        send_word(16'hA55A);
        send_word(16'h1234);
        cs_end();
`ifndef SPI_ADDR_HEADER_EN
        check("t1_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t1_w0", seen_q[0], 32'h0000_A55A);
            check("t1_w1", seen_q[1], 32'h0001_1234);
        end
`endif

        // 2: trailing partial byte is dropped, next frame restarts at 0
        cs_start();
        send_word(16'hBEEF);
        send_bits(16'h00CC, 8);
        cs_end();
`ifndef SPI_ADDR_HEADER_EN
        check("t2_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) check("t2_w0", seen_q[0], 32'h0000_BEEF);
`endif
        cs_start();
        send_word(16'h0F0F);
        cs_end();
`ifndef SPI_ADDR_HEADER_EN
        if (seen_q.size() >= 1) check("t2_restart", seen_q[0], 32'h0000_0F0F);
`endif

        // 5: SCK activity with CS high is ignored
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        #100;
        check("t5_no_frame_done", 32'(seen_done), 32'(exp_done));
        check("t5_no_strobe", 32'(seen_q.size()), 32'(HDR ? 0 : 1));

        // random frames of arbitrary length
        for (int f = 0; f < 5; f++) begin
            int n;
            cs_start();
            n = $urandom_range(0, 64);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            cs_end();
            #($urandom_range(0, 5) * 20);
        end

        // 4: reset mid-word aborts without strobe or frame_done
        cs_start();
        send_word(16'hFFFF);
        send_word(16'h8001);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t4_reset");
        spi_cs_n = 1'b1;
        #49 reset_n = 1'b1;
        #50;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        #100;
        check("t4_no_frame_done", 32'(seen_done), 32'(exp_done));
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 3: fill the buffer, then one word too many
        cs_start();
        for (int i = 0; i < NUM_WORDS; i++) send_word(16'($urandom));
        #200;
        check("t3_ovf_before_drop", 32'(overflow), 32'(m_ovf));
        send_word(16'($urandom));
        cs_end();
`ifndef SPI_ADDR_HEADER_EN
        check("t3_count", 32'(seen_q.size()), 32'(NUM_WORDS));
        if (seen_q.size() > 0) check("t3_last_addr", 32'(seen_q[$] >> 16), 32'd1304);
        check("t3_overflow", 32'(overflow), 32'd1);
`endif

`ifdef SPI_ADDR_HEADER_EN
        // 6: start-address header
        cs_start();
        send_word(16'h0010);
        send_word(16'h00FF);
        cs_end();
        check("t6_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) check("t6_w0", seen_q[0], 32'h0010_00FF);
        cs_start();
        send_word(16'h0519);
        cs_end();
        check("t6_hdr_count", 32'(seen_q.size()), 32'd0);
        check("t6_hdr_overflow", 32'(overflow), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
